// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter that feeds one byte at a time from NREQ requesters
// into a single UART transmitter, with an idle guard of GAP_CYCLES after each byte.
// Optional watchdog on the transmitter handshake: define UART_ARB_TIMEOUT_EN.
module uart_tx_arb #(
    parameter int unsigned NREQ           = 4,
    parameter int unsigned GAP_CYCLES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1100000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*8-1:0]       req_data,
    output logic [NREQ-1:0]         ack,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    busy,
    output logic                    tx_wr_en,
    output logic [7:0]              tx_data,
    input  logic                    tx_wr_done,
    output logic                    err_timeout
);

    localparam int unsigned     IdW     = $clog2(NREQ);
    localparam int unsigned     GapW    = $clog2(GAP_CYCLES + 1);
    localparam logic [IdW-1:0]  PtrRst  = IdW'(NREQ - 1);
    localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StWaitDone, StGap} state_e;

    state_e          state;
    logic [IdW-1:0]  ptr;
    logic [GapW-1:0] gap_cnt;
    logic            found;
    logic [IdW-1:0]  winner;
    logic [7:0]      win_data;
    int unsigned     cand;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int unsigned    WdW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYCLES - 1);
    logic [WdW-1:0] wd_cnt;
`else
    assign err_timeout = 1'b0;
`endif

    // First requesting index searching upward from one past the last grant.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = 0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            cand = (32'(ptr) + i) % NREQ;
            if (!found && req[cand[IdW-1:0]]) begin
                found  = 1'b1;
                winner = cand[IdW-1:0];
            end
        end
    end

    // Byte lane of the current winner.
    always_comb begin
        win_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (winner == IdW'(i)) begin
                win_data = req_data[8*i +: 8];
            end
        end
    end

    assign busy = (state != StIdle);

    // Arbitration FSM with all outputs registered; ack/strobe are single-cycle pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= StIdle;
            ptr      <= PtrRst;
            grant_id <= '0;
            ack      <= '0;
            tx_wr_en <= 1'b0;
            tx_data  <= '0;
            gap_cnt  <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            wd_cnt      <= '0;
            err_timeout <= 1'b0;
`endif
        end else begin
            ack      <= '0;
            tx_wr_en <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            err_timeout <= 1'b0;
`endif
            case (state)
                StIdle: begin
                    if (found) begin
                        state       <= StWaitDone;
                        ptr         <= winner;
                        grant_id    <= winner;
                        tx_data     <= win_data;
                        ack[winner] <= 1'b1;
                        tx_wr_en    <= 1'b1;
`ifdef UART_ARB_TIMEOUT_EN
                        wd_cnt <= '0;
`endif
                    end
                end
                StWaitDone: begin
                    // Completion beats an expiring watchdog on the same cycle.
                    if (tx_wr_done) begin
                        state   <= StGap;
                        gap_cnt <= '0;
                    end
`ifdef UART_ARB_TIMEOUT_EN
                    else if (wd_cnt == WdLast) begin
                        err_timeout <= 1'b1;
                        state       <= StGap;
                        gap_cnt     <= '0;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
`endif
                end
                StGap: begin
                    if (gap_cnt == GapLast) begin
                        state   <= StIdle;
                        gap_cnt <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: directed scenarios plus a randomized phase,
// all compared every cycle against a transaction-level model of the arbiter.
module tb_uart_tx_arb;

    localparam int N = 4;
    localparam int G = 4;
    localparam int T = 50;
`ifdef UART_ARB_TIMEOUT_EN
    localparam bit TO_ON = 1'b1;
`else
    localparam bit TO_ON = 1'b0;
`endif

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*8-1:0] req_data;
    logic [N-1:0]   ack;
    logic [1:0]     grant_id;
    logic           busy;
    logic           tx_wr_en;
    logic [7:0]     tx_data;
    logic           tx_wr_done;
    logic           err_timeout;

    uart_tx_arb #(
        .NREQ           (N),
        .GAP_CYCLES     (G),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_data    (req_data),
        .ack         (ack),
        .grant_id    (grant_id),
        .busy        (busy),
        .tx_wr_en    (tx_wr_en),
        .tx_data     (tx_data),
        .tx_wr_done  (tx_wr_done),
        .err_timeout (err_timeout)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "time limit");
    end

    // Stimulus controls written by the main sequence, applied by the driver.
    int             mode    = 0;   // 0 directed, 1 random
    bit             auto_on = 1'b0;
    int             auto_d  = 20;
    logic [N-1:0]   d_req   = '0;
    logic [N*8-1:0] d_data  = '0;
    logic           d_done  = 1'b0;

    // Sole driver of req/req_data/tx_wr_done, updated 2 time units after each edge.
    initial begin
        int rem;
        rem        = 0;
        req        = '0;
        req_data   = '0;
        tx_wr_done = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (tx_wr_en === 1'b1) rem = auto_d;
            else if (rem > 0) rem--;
            if (mode == 1) begin
                for (int i = 0; i < N; i++) begin
                    if (req[i] && ack[i]) begin
                        req[i] = 1'b0;
                    end else if (!req[i] && $urandom_range(3) == 0) begin
                        req[i]             = 1'b1;
                        req_data[8*i +: 8] = 8'($urandom);
                    end
                end
                tx_wr_done = ($urandom_range(5) == 0);
            end else begin
                req        = d_req;
                req_data   = d_data;
                tx_wr_done = auto_on ? (rem == 1) : d_done;
            end
        end
    end

    // Transaction-level model: a frame is open from grant until completion/timeout;
    // arbitration is allowed again G+1 edges after the frame closes.
    int         cyc = 0;
    bit         in_frame;
    int         last;
    int         arb_ok;
    int         nn;
    int         strobe_n;
    logic [3:0] e_ack;
    logic       e_en;
    logic [7:0] e_data;
    logic [1:0] e_gid;
    logic       e_err;
    logic       e_busy;

    function automatic int pick(input logic [N-1:0] r, input int lst);
        int best;
        int bestd;
        best  = -1;
        bestd = N;
        for (int i = 0; i < N; i++) begin
            if (r[i] && ((i - lst - 1 + 2 * N) % N) < bestd) begin
                bestd = (i - lst - 1 + 2 * N) % N;
                best  = i;
            end
        end
        return best;
    endfunction

    initial begin
        int w;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst_n !== 1'b1) begin
                in_frame = 1'b0;
                last     = N - 1;
                arb_ok   = 0;
                nn       = 0;
                strobe_n = 0;
                e_ack    = '0;
                e_en     = 1'b0;
                e_data   = '0;
                e_gid    = '0;
                e_err    = 1'b0;
                e_busy   = 1'b0;
            end else begin
                e_ack = '0;
                e_en  = 1'b0;
                e_err = 1'b0;
                if (!in_frame && nn >= arb_ok) begin
                    if (req != '0) begin
                        w        = pick(req, last);
                        last     = w;
                        e_gid    = 2'(w);
                        e_data   = req_data[8*w +: 8];
                        e_ack    = 4'(1 << w);
                        e_en     = 1'b1;
                        in_frame = 1'b1;
                        strobe_n = nn;
                    end
                end else if (in_frame) begin
                    if (tx_wr_done) begin
                        in_frame = 1'b0;
                        arb_ok   = nn + G + 1;
                    end else if (TO_ON && (nn - strobe_n) == T) begin
                        e_err    = 1'b1;
                        in_frame = 1'b0;
                        arb_ok   = nn + G + 1;
                    end
                end
                e_busy = in_frame || (nn + 1 < arb_ok);
                nn++;
            end
        end
    end

    // Strobe log and per-cycle comparison against the model, on the falling edge.
    int log_cyc[$];
    int log_id[$];

    initial begin
        forever begin
            @(negedge clk);
            if (tx_wr_en === 1'b1) begin
                log_cyc.push_back(cyc);
                log_id.push_back(int'(grant_id));
            end
            if (rst_n !== 1'b1) begin
                chk("rst_ack", 32'(ack), 0);
                chk("rst_en", 32'(tx_wr_en), 0);
                chk("rst_busy", 32'(busy), 0);
                chk("rst_err", 32'(err_timeout), 0);
            end else begin
                chk("ack", 32'(ack), 32'(e_ack));
                chk("tx_wr_en", 32'(tx_wr_en), 32'(e_en));
                chk("tx_data", 32'(tx_data), 32'(e_data));
                chk("grant_id", 32'(grant_id), 32'(e_gid));
                chk("busy", 32'(busy), 32'(e_busy));
                chk("err_timeout", 32'(err_timeout), 32'(e_err));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_hold();
        rst_n = 1'b0;
        repeat (2) tick();
    endtask

    task automatic wait_strobes(input int cnt, input int budget);
        int k;
        k = 0;
        while (log_id.size() < cnt && k < budget) begin
            tick();
            k++;
        end
        if (log_id.size() < cnt) chk("strobe_wait", 32'(log_id.size()), 32'(cnt));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ack"}, 32'(ack), 0);
        chk({tag, "_en"}, 32'(tx_wr_en), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_gid"}, 32'(grant_id), 0);
        chk({tag, "_data"}, 32'(tx_data), 0);
        chk({tag, "_err"}, 32'(err_timeout), 0);
    endtask

    initial begin
        int exp_ids[5];
        int s;
        int err_c;
        int k;
        exp_ids = '{0, 1, 2, 3, 0};
        rst_n   = 1'b0;
        repeat (3) tick();
        chk_reset_outputs("reset");

        // First grant after reset, then repeated grants to a lone requester.
        d_req   = 4'b0001;
        d_data  = {8'h44, 8'h33, 8'h22, 8'hA5};
        auto_d  = 20;
        auto_on = 1'b1;
        log_cyc.delete();
        log_id.delete();
        rst_n = 1'b1;
        tick();
        chk("first_en", 32'(tx_wr_en), 1);
        chk("first_ack", 32'(ack), 32'h1);
        chk("first_data", 32'(tx_data), 32'hA5);
        chk("first_gid", 32'(grant_id), 0);
        chk("first_busy", 32'(busy), 1);
        tick();
        chk("pulse_en", 32'(tx_wr_en), 0);
        chk("pulse_ack", 32'(ack), 0);
        wait_strobes(2, 100);
        if (log_id.size() >= 2) begin
            chk("single_regrant_id", 32'(log_id[1]), 0);
            chk("single_regrant_gap", 32'(log_cyc[1] - log_cyc[0]), 32'(20 + G + 1));
        end

        // All four requesting: round-robin order and strobe spacing.
        reset_hold();
        d_req  = 4'b1111;
        d_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        log_cyc.delete();
        log_id.delete();
        rst_n = 1'b1;
        wait_strobes(5, 300);
        for (int i = 0; i < 5; i++) begin
            if (i < log_id.size()) begin
                chk($sformatf("rr_id%0d", i), 32'(log_id[i]), 32'(exp_ids[i]));
                if (i > 0) chk($sformatf("rr_gap%0d", i), 32'(log_cyc[i] - log_cyc[i-1]),
                               32'(20 + G + 1));
            end
        end

        // Request change during WAIT_DONE is ignored until the gap completes.
        reset_hold();
        d_req = 4'b0100;
        log_cyc.delete();
        log_id.delete();
        rst_n = 1'b1;
        wait_strobes(1, 20);
        if (log_id.size() >= 1) chk("chg_first_id", 32'(log_id[0]), 2);
        d_req = 4'b0101;
        wait_strobes(2, 200);
        if (log_id.size() >= 2) begin
            chk("chg_next_id", 32'(log_id[1]), 0);
            chk("chg_next_gap", 32'(log_cyc[1] - log_cyc[0]), 32'(20 + G + 1));
        end

        // Reset in the middle of a frame.
        auto_on = 1'b0;
        d_req   = '0;
        rst_n   = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (10) begin
            tick();
            chk("post_rst_ack", 32'(ack), 0);
            chk("post_rst_busy", 32'(busy), 0);
            chk("post_rst_en", 32'(tx_wr_en), 0);
        end

        // tx_wr_done in IDLE with no requests changes nothing.
        d_req   = 4'b0010;
        d_data  = {8'h00, 8'h00, 8'h5A, 8'h00};
        auto_on = 1'b1;
        log_cyc.delete();
        log_id.delete();
        wait_strobes(1, 20);
        d_req = '0;
        k = 0;
        while (busy === 1'b1 && k < 60) begin
            tick();
            k++;
        end
        chk("idle_reached", 32'(busy), 0);
        auto_on = 1'b0;
        d_done  = 1'b1;
        tick();
        d_done = 1'b0;
        repeat (4) begin
            chk("idle_done_busy", 32'(busy), 0);
            chk("idle_done_ack", 32'(ack), 0);
            chk("idle_done_en", 32'(tx_wr_en), 0);
            chk("idle_done_gid", 32'(grant_id), 1);
            chk("idle_done_data", 32'(tx_data), 32'h5A);
            tick();
        end

        // Transmitter never completes.
        d_req  = 4'b0001;
        d_data = {8'h00, 8'h00, 8'h00, 8'h77};
        log_cyc.delete();
        log_id.delete();
        wait_strobes(1, 20);
        d_req = '0;
        s     = (log_cyc.size() > 0) ? log_cyc[0] : 0;
`ifdef UART_ARB_TIMEOUT_EN
        err_c = -1;
        repeat (100) begin
            tick();
            if (err_timeout === 1'b1 && err_c < 0) err_c = cyc;
        end
        chk("timeout_latency", 32'(err_c - s), 32'(T));
        chk("timeout_idle", 32'(busy), 0);
`else
        err_c = s;
        repeat (100) tick();
        chk("no_wd_busy", 32'(busy), 1);
        chk("no_wd_err", 32'(err_timeout), 0);
`endif

        // Randomized traffic with one asynchronous reset in the middle.
        reset_hold();
        mode  = 1;
        rst_n = 1'b1;
        repeat (2000) tick();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2000) tick();
        mode = 0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 The module SHALL have parameter NREQ, default 4, giving the number of requesters (2..8).
REQ-002 The module SHALL have parameter GAP_CYCLES, default 4, giving the idle guard in clocks after each byte completes (>=1).
REQ-003 The module SHALL have parameter TIMEOUT_CYCLES, default 1100000, giving the watchdog limit used only with UART_ARB_TIMEOUT_EN.
REQ-004 Port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-005 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 Port req, input, NREQ: per-requester byte-send request, level, held until the matching ack.
REQ-007 Port req_data, input, NREQ*8: byte for requester i is on bits [8i+7:8i], held stable while req[i]=1.
REQ-008 Port ack, output, NREQ: one-cycle pulse on bit i when requester i's byte is latched.
REQ-009 Port grant_id, output, clog2(NREQ): index of the last granted requester.
REQ-010 Port busy, output, 1: high whenever the state is not IDLE.
REQ-011 Port tx_wr_en, output, 1: write strobe to the UART transmitter.
REQ-012 Port tx_data, output, 8: byte presented to the transmitter.
REQ-013 Port tx_wr_done, input, 1: end-of-stop-bit indication from the transmitter.
REQ-014 Port err_timeout, output, 1: one-cycle pulse on watchdog abort; tied 0 without the macro.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT_DONE and GAP, and no others.
REQ-016 In IDLE with req!=0, the block SHALL select the first set bit searching upward from (ptr+1) mod NREQ, where ptr is the last granted index.
REQ-017 On that edge the block SHALL register tx_data, set grant_id and ptr to the winner, and pulse ack[winner] and tx_wr_en for exactly one cycle.
REQ-018 On that same edge the FSM SHALL enter WAIT_DONE, so ack and tx_wr_en are visible one cycle after req is sampled.
REQ-019 tx_wr_en SHALL NOT be asserted in any state other than on the IDLE-exit edge, so it is never high during a frame.
REQ-020 tx_data SHALL hold its value from grant until the next grant.
REQ-021 In WAIT_DONE, tx_wr_done=1 SHALL load the gap counter with 0 and move the FSM to GAP.
REQ-022 req changes during WAIT_DONE or GAP SHALL be ignored.
REQ-023 In GAP, the counter SHALL increment each cycle and the FSM SHALL return to IDLE after GAP_CYCLES cycles in GAP.
REQ-024 Arbitration SHALL occur only in IDLE, so a requester still asserting req after its ack is granted again only per the round-robin order.
REQ-025 A single active requester SHALL be re-granted on every IDLE visit.
REQ-026 tx_wr_done seen in IDLE or GAP SHALL be ignored.

Reset
REQ-027 While rst_n=0, the block SHALL hold state=IDLE, ptr=NREQ-1 (so requester 0 wins first), grant_id=0, ack=0, tx_wr_en=0, tx_data=0, busy=0, err_timeout=0 and all counters at 0.
REQ-028 Reset asserted mid-frame SHALL abandon the frame immediately with no ack or strobe, and no state SHALL be retained.

Configuration
REQ-029 With UART_ARB_TIMEOUT_EN defined, a watchdog SHALL count cycles in WAIT_DONE.
REQ-030 When the watchdog reaches TIMEOUT_CYCLES-1 without tx_wr_done, the block SHALL pulse err_timeout once and enter GAP.
REQ-031 With UART_ARB_TIMEOUT_EN defined, tx_wr_done on the same cycle as expiry SHALL win (normal completion, no err_timeout pulse).
REQ-032 Without UART_ARB_TIMEOUT_EN, no watchdog logic SHALL be present, err_timeout SHALL be constant 0, and WAIT_DONE SHALL wait indefinitely.

Verification
REQ-033 Reset release with req=4'b0001, req_data[7:0]=8'hA5 -> tx_wr_en and ack[0] pulse one cycle later with tx_data=8'hA5, grant_id=0, busy=1.
REQ-034 req=4'b1111 held and tx_wr_done pulsed 20 cycles after each strobe -> grants in order 0,1,2,3,0 with each strobe exactly 20+GAP_CYCLES+1 cycles after the previous.
REQ-035 After requester 2 is granted, req changes to 4'b0101 during WAIT_DONE -> next grant is 0, not 2, and not before GAP completes.
REQ-036 rst_n pulled low in WAIT_DONE, then released with req=0 -> all outputs at reset values, busy=0, and no ack pulse.
REQ-037 With UART_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=50 and tx_wr_done never asserted -> err_timeout pulses 50 cycles after the strobe, then IDLE after GAP; without the macro, busy stays 1.
REQ-038 tx_wr_done asserted in IDLE with req=0 -> no state change and no outputs toggle.
